// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the reg_file_sb register file slice.
package reg_file_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2;

  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_DW-1:0] reg_data_t;

  // R3=07, R2=00, R1=00, R0=01 for the default 4x8 configuration
  localparam logic [31:0] DEF_INIT_VEC = {8'h07, 8'h00, 8'h00, 8'h01};

endpackage

// File: rtl/reg_file_sb_if.sv
// Control-unit side bus of the register file: read/write ports, lock request and scoreboard status.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  logic              we;
  logic [AW-1:0]     dr;
  logic [DW-1:0]     i;
  logic [AW-1:0]     sr;
  logic [DW-1:0]     s;
  logic [DW-1:0]     d;
  logic              lock_req;
  logic [AW-1:0]     lock_addr;
  logic [2**AW-1:0]  busy;
  logic              stall;

  modport master (
    output we, dr, i, sr, lock_req, lock_addr,
    input  s, d, busy, stall
  );

  modport slave (
    input  we, dr, i, sr, lock_req, lock_addr,
    output s, d, busy, stall
  );
endinterface

// File: rtl/reg_lock_table.sv
// Per-register pending flags (set by lock, cleared by write, lock wins) and stall generation.
// REG_FILE_BYPASS_EN: the register being written is masked from stall unless it is re-locked.
module reg_lock_table #(
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [AW-1:0]     sr,
  input  logic [AW-1:0]     dr,
  output logic [2**AW-1:0]  busy,
  output logic              stall
);
  localparam int NREG = 2**AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] mask;
  logic [NREG-1:0] busy_eff;

  // Set is applied after clear so a same-address lock keeps the flag pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (clr_en) busy_q[clr_addr] <= 1'b0;
      if (set_en) busy_q[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    mask = '0;
`ifdef REG_FILE_BYPASS_EN
    if (clr_en && !(set_en && (set_addr == clr_addr)))
      mask[clr_addr] = 1'b1;
`endif
  end

  assign busy_eff = busy_q & ~mask;
  assign busy     = busy_q;
  assign stall    = busy_eff[sr] | busy_eff[dr];

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with one source read port, one destination read/write port and lock scoreboard.
// REG_FILE_BYPASS_EN: same-cycle write data is forwarded to s/d and stall.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter logic [(2**AW)*DW-1:0] INIT_VEC = ((2**AW)*DW)'(DEF_INIT_VEC)
) (
  input  logic clk,
  input  logic rst,
  reg_file_sb_if.slave bus
);
  localparam int NREG = 2**AW;

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        mem[k] <= INIT_VEC[k*DW +: DW];
    end else if (bus.we) begin
      mem[bus.dr] <= bus.i;
    end
  end

  always_comb begin
    bus.s = mem[bus.sr];
    bus.d = mem[bus.dr];
`ifdef REG_FILE_BYPASS_EN
    if (bus.we) begin
      bus.d = bus.i;
      if (bus.dr == bus.sr) bus.s = bus.i;
    end
`endif
  end

  reg_lock_table #(.AW(AW)) u_lock (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.lock_req),
    .set_addr (bus.lock_addr),
    .clr_en   (bus.we),
    .clr_addr (bus.dr),
    .sr       (bus.sr),
    .dr       (bus.dr),
    .busy     (bus.busy),
    .stall    (bus.stall)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb (default 4x8 configuration, either REG_FILE_BYPASS_EN build).
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NREG = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DW(DW), .AW(AW)) bus ();

  reg_file_sb #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0]   s;
    logic [DW-1:0]   d;
    logic [NREG-1:0] busy;
    logic            stall;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] m_mem [NREG];
  logic [NREG-1:0] m_busy;
  bit            m_valid = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference update from the inputs present at the rising edge.
  task automatic commit();
    logic [31:0] iv;
    iv = 32'h07000001;
    if (rst) begin
      for (int k = 0; k < NREG; k++) m_mem[k] = iv[k*8 +: 8];
      m_busy  = '0;
      m_valid = 1'b1;
    end else begin
      if (bus.we) begin
        m_mem[bus.dr]  = bus.i;
        m_busy[bus.dr] = 1'b0;
      end
      if (bus.lock_req) m_busy[bus.lock_addr] = 1'b1;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic [NREG-1:0] eb;
    e.s    = m_mem[bus.sr];
    e.d    = m_mem[bus.dr];
    e.busy = m_busy;
    eb     = m_busy;
`ifdef REG_FILE_BYPASS_EN
    if (bus.we) begin
      e.d = bus.i;
      if (bus.sr == bus.dr) e.s = bus.i;
      if (!(bus.lock_req && bus.lock_addr == bus.dr)) eb[bus.dr] = 1'b0;
    end
`endif
    e.stall = eb[bus.sr] | eb[bus.dr];
    return e;
  endfunction

  task automatic step(input bit r, input bit w, input logic [1:0] dra, input logic [7:0] iv,
                      input logic [1:0] sra, input bit lr, input logic [1:0] la);
    exp_t e;
    @(posedge clk);
    commit();
    @(negedge clk);
    rst = r; bus.we = w; bus.dr = dra; bus.i = iv;
    bus.sr = sra; bus.lock_req = lr; bus.lock_addr = la;
    if (m_valid) sbq.push_back(predict());
    #1;
    if (m_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("s",     32'(bus.s),     32'(e.s));
      chk("d",     32'(bus.d),     32'(e.d));
      chk("busy",  32'(bus.busy),  32'(e.busy));
      chk("stall", 32'(bus.stall), 32'(e.stall));
    end
  endtask

  initial begin
    rst = 1'b1; bus.we = 1'b0; bus.dr = '0; bus.i = '0;
    bus.sr = '0; bus.lock_req = 1'b0; bus.lock_addr = '0;

    // reset values
    step(0, 0, 2'd0, 8'h00, 2'd0, 0, 2'd0);
    chk("rst_s0", 32'(bus.s), 32'h01);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    step(0, 0, 2'd2, 8'h00, 2'd3, 0, 2'd0);
    chk("rst_s3", 32'(bus.s), 32'h07);
    chk("rst_d2", 32'(bus.d), 32'h00);
    step(0, 0, 2'd2, 8'h00, 2'd1, 0, 2'd0);
    chk("rst_s1", 32'(bus.s), 32'h00);

    // write latency
    step(0, 1, 2'd2, 8'hA5, 2'd2, 0, 2'd0);
`ifdef REG_FILE_BYPASS_EN
    chk("wr_cyc_s", 32'(bus.s), 32'hA5);
`else
    chk("wr_cyc_s", 32'(bus.s), 32'h00);
`endif
    step(0, 0, 2'd2, 8'h00, 2'd2, 0, 2'd0);
    chk("wr_s2", 32'(bus.s), 32'hA5);
    chk("wr_d2", 32'(bus.d), 32'hA5);

    // lock then clear by write
    step(0, 0, 2'd0, 8'h00, 2'd0, 1, 2'd1);
    step(0, 0, 2'd0, 8'h00, 2'd1, 0, 2'd0);
    chk("lk_busy", 32'(bus.busy), 32'b0010);
    chk("lk_stall", 32'(bus.stall), 32'h1);
    step(0, 1, 2'd1, 8'h3C, 2'd1, 0, 2'd0);
    step(0, 0, 2'd1, 8'h00, 2'd1, 0, 2'd0);
    chk("clr_busy", 32'(bus.busy), 32'h0);
    chk("clr_stall", 32'(bus.stall), 32'h0);
    chk("clr_s1", 32'(bus.s), 32'h3C);

    // write and lock same register: lock wins
    step(0, 1, 2'd3, 8'h55, 2'd3, 1, 2'd3);
    step(0, 1, 2'd2, 8'h11, 2'd3, 1, 2'd0);
    chk("wl_s3", 32'(bus.s), 32'h55);
    chk("wl_busy", 32'(bus.busy), 32'b1000);
    chk("wl_stall", 32'(bus.stall), 32'h1);
    step(0, 0, 2'd0, 8'h00, 2'd0, 0, 2'd0);
    chk("wl_busy2", 32'(bus.busy), 32'b1001);

    // reset mid-sequence discards the same-cycle write and lock
    step(0, 0, 2'd0, 8'h00, 2'd0, 1, 2'd2);
    step(0, 1, 2'd1, 8'hFF, 2'd1, 0, 2'd0);
    step(1, 1, 2'd1, 8'h12, 2'd1, 1, 2'd3);
    step(0, 0, 2'd3, 8'h00, 2'd0, 0, 2'd0);
    chk("mr_s0", 32'(bus.s), 32'h01);
    chk("mr_d3", 32'(bus.d), 32'h07);
    chk("mr_busy", 32'(bus.busy), 32'h0);
    step(0, 0, 2'd2, 8'h00, 2'd1, 0, 2'd0);
    chk("mr_s1", 32'(bus.s), 32'h00);
    chk("mr_d2", 32'(bus.d), 32'h00);

    // bypass of a locked register being written
    step(0, 0, 2'd0, 8'h00, 2'd0, 1, 2'd2);
    step(0, 1, 2'd2, 8'h9E, 2'd2, 0, 2'd0);
`ifdef REG_FILE_BYPASS_EN
    chk("bp_s", 32'(bus.s), 32'h9E);
    chk("bp_d", 32'(bus.d), 32'h9E);
    chk("bp_stall", 32'(bus.stall), 32'h0);
`else
    chk("bp_s", 32'(bus.s), 32'h00);
    chk("bp_d", 32'(bus.d), 32'h00);
    chk("bp_stall", 32'(bus.stall), 32'h1);
`endif

    // random traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
           2'($urandom), 1'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
